// File: rtl/graphics_pkg.sv
// Shared screen geometry, write-bus idle values and the corner sort/clamp helper
// used by the frame-buffer drawing primitives.
package graphics_pkg;

   localparam int HOR_ACTIVE_PIXELS = 640;
   localparam int VER_ACTIVE_PIXELS = 480;

   localparam int X_WIDTH      = $clog2(HOR_ACTIVE_PIXELS);
   localparam int Y_WIDTH      = $clog2(VER_ACTIVE_PIXELS);
   localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
   localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT);

   // Common width wide enough for either axis, so one helper serves both.
   localparam int C_WIDTH = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;

   // The write bus is OR-combined between drawers: an idle drawer drives zeros.
   localparam logic [ADDR_WIDTH-1:0] BUS_IDLE_ADDR = '0;
   localparam logic                  BUS_IDLE_DATA = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DRAW = 1'b1
   } draw_state_t;

   typedef struct packed {
      logic [C_WIDTH-1:0] lo;
      logic [C_WIDTH-1:0] hi;
   } span_t;

   // Clamp both coordinates to the last visible index, then order them.
   function automatic span_t clamp_sort(input logic [C_WIDTH-1:0] a,
                                        input logic [C_WIDTH-1:0] b,
                                        input logic [C_WIDTH-1:0] limit);
      logic [C_WIDTH-1:0] ca;
      logic [C_WIDTH-1:0] cb;
      span_t              s;
      ca = (a > limit) ? limit : a;
      cb = (b > limit) ? limit : b;
      if (ca <= cb) begin
         s.lo = ca;
         s.hi = cb;
      end else begin
         s.lo = cb;
         s.hi = ca;
      end
      return s;
   endfunction

endpackage

// File: rtl/rect_drawer_if.sv
// Command and write-bus signals of rect_drawer. master = requester
// (graphics_fsm side), slave = the drawer itself.
interface rect_drawer_if;
   import graphics_pkg::*;

   logic                  start;
   logic                  ready;
   logic [X_WIDTH-1:0]    x1;
   logic [Y_WIDTH-1:0]    y1;
   logic [X_WIDTH-1:0]    x2;
   logic [Y_WIDTH-1:0]    y2;
   logic                  filled;
   logic                  color;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic                  write_data;

   modport master (
      output start, x1, y1, x2, y2, filled, color,
      input  ready, write_enable, write_addr, write_data
   );

   modport slave (
      input  start, x1, y1, x2, y2, filled, color,
      output ready, write_enable, write_addr, write_data
   );

endinterface

// File: rtl/rect_drawer.sv
// Axis-aligned rectangle rasteriser (filled or 1-pixel outline), one registered
// frame-buffer write per clock in row-major order.
module rect_drawer
   import graphics_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   rect_drawer_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
   localparam logic [C_WIDTH-1:0]    X_LIMIT    = C_WIDTH'(HOR_ACTIVE_PIXELS - 1);
   localparam logic [C_WIDTH-1:0]    Y_LIMIT    = C_WIDTH'(VER_ACTIVE_PIXELS - 1);

   draw_state_t           r_state;
   logic                  r_ready;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_data;
   logic [X_WIDTH-1:0]    r_x;
   logic [Y_WIDTH-1:0]    r_y;
   logic [X_WIDTH-1:0]    r_xmin;
   logic [X_WIDTH-1:0]    r_xmax;
   logic [Y_WIDTH-1:0]    r_ymin;
   logic [Y_WIDTH-1:0]    r_ymax;
   logic [ADDR_WIDTH-1:0] r_row_base;
   logic                  r_filled;
   logic                  r_color;

   span_t                 w_xspan;
   span_t                 w_yspan;
   logic [X_WIDTH-1:0]    w_xmin;
   logic [X_WIDTH-1:0]    w_xmax;
   logic [Y_WIDTH-1:0]    w_ymin;
   logic [Y_WIDTH-1:0]    w_ymax;
   logic [ADDR_WIDTH-1:0] w_start_base;
   logic                  w_row_end;
   logic                  w_last;
   logic                  w_edge_row;
   logic [X_WIDTH-1:0]    w_x_next;
   logic [Y_WIDTH-1:0]    w_y_next;
   logic [ADDR_WIDTH-1:0] w_base_next;

   // Corner ordering/clamping and the single row-base multiply used at latch time.
   always_comb begin
      w_xspan      = clamp_sort(C_WIDTH'(bus.x1), C_WIDTH'(bus.x2), X_LIMIT);
      w_yspan      = clamp_sort(C_WIDTH'(bus.y1), C_WIDTH'(bus.y2), Y_LIMIT);
      w_xmin       = w_xspan.lo[X_WIDTH-1:0];
      w_xmax       = w_xspan.hi[X_WIDTH-1:0];
      w_ymin       = w_yspan.lo[Y_WIDTH-1:0];
      w_ymax       = w_yspan.hi[Y_WIDTH-1:0];
      w_start_base = ADDR_WIDTH'(w_ymin) * ROW_STRIDE;
   end

   // Next pixel after the one currently on the bus; outline interior rows skip
   // straight from xmin to xmax, and a row end wraps with an added stride.
   always_comb begin
      w_row_end   = (r_x == r_xmax);
      w_last      = w_row_end && (r_y == r_ymax);
      w_edge_row  = (r_y == r_ymin) || (r_y == r_ymax);
      w_x_next    = r_x + 1'b1;
      w_y_next    = r_y;
      w_base_next = r_row_base;
      if (w_row_end) begin
         w_x_next    = r_xmin;
         w_y_next    = r_y + 1'b1;
         w_base_next = r_row_base + ROW_STRIDE;
      end else if (!r_filled && !w_edge_row) begin
         w_x_next = r_xmax;
      end
   end

   // Control FSM with registered bus outputs; the bus returns to zeros when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b1;
         r_we       <= 1'b0;
         r_addr     <= BUS_IDLE_ADDR;
         r_data     <= BUS_IDLE_DATA;
         r_x        <= '0;
         r_y        <= '0;
         r_xmin     <= '0;
         r_xmax     <= '0;
         r_ymin     <= '0;
         r_ymax     <= '0;
         r_row_base <= '0;
         r_filled   <= 1'b0;
         r_color    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state    <= ST_DRAW;
                  r_ready    <= 1'b0;
                  r_xmin     <= w_xmin;
                  r_xmax     <= w_xmax;
                  r_ymin     <= w_ymin;
                  r_ymax     <= w_ymax;
                  r_filled   <= bus.filled;
                  r_color    <= bus.color;
                  r_x        <= w_xmin;
                  r_y        <= w_ymin;
                  r_row_base <= w_start_base;
                  // First pixel goes out immediately so the write lands one
                  // cycle after start.
                  r_we       <= 1'b1;
                  r_addr     <= w_start_base + ADDR_WIDTH'(w_xmin);
                  r_data     <= bus.color;
               end
            end
            ST_DRAW: begin
               if (w_last) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_we    <= 1'b0;
                  r_addr  <= BUS_IDLE_ADDR;
                  r_data  <= BUS_IDLE_DATA;
               end else begin
                  r_x        <= w_x_next;
                  r_y        <= w_y_next;
                  r_row_base <= w_base_next;
                  r_we       <= 1'b1;
                  r_addr     <= w_base_next + ADDR_WIDTH'(w_x_next);
                  r_data     <= r_color;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_we    <= 1'b0;
               r_addr  <= BUS_IDLE_ADDR;
               r_data  <= BUS_IDLE_DATA;
            end
         endcase
      end
   end

   assign bus.ready        = r_ready;
   assign bus.write_enable = r_we;
   assign bus.write_addr   = r_addr;
   assign bus.write_data   = r_data;

endmodule
